// File: rtl/uart_baud_gen_if.sv
// Control and tick bundle of the UART baud generator. The master side
// programs the divisor and phase; the slave side (the generator) returns
// the oversample, bit-centre and bit-boundary ticks.
interface uart_baud_gen_if #(
  parameter int CNT_WIDTH  = 16,
  parameter int FRAC_WIDTH = 4
);
  logic                  en;
  logic                  load;
  logic [CNT_WIDTH-1:0]  div_in;
  logic [FRAC_WIDTH-1:0] frac_in;
  logic                  resync;
  logic                  os_tick;
  logic                  mid_tick;
  logic                  bit_tick;

  modport master (
    output en, load, div_in, frac_in, resync,
    input  os_tick, mid_tick, bit_tick
  );

  modport slave (
    input  en, load, div_in, frac_in, resync,
    output os_tick, mid_tick, bit_tick
  );
endinterface

// File: rtl/uart_baud_gen.sv
// Fractional baud-rate generator. A down-counter produces one os_tick every
// active_div (+1 on accumulator carry) clocks, giving an average period of
// active_div + active_frac/2^FRAC_WIDTH. An oversample index derives the
// bit-centre and bit-boundary ticks. New divisors are staged in shadow
// registers and applied at a period boundary so a running period is never cut.
module uart_baud_gen #(
  parameter int CNT_WIDTH   = 16,
  parameter int FRAC_WIDTH  = 4,
  parameter int OVERSAMPLE  = 16,
  parameter int DEFAULT_DIV = 1000
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_baud_gen_if.slave bus
);

  localparam int IDX_WIDTH = $clog2(OVERSAMPLE);

  localparam logic [CNT_WIDTH-1:0] DIV_RST  = CNT_WIDTH'(DEFAULT_DIV);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_TWO  = CNT_WIDTH'(2);
  localparam logic [IDX_WIDTH-1:0] IDX_LAST = IDX_WIDTH'(OVERSAMPLE - 1);
  localparam logic [IDX_WIDTH-1:0] IDX_MID  = IDX_WIDTH'(OVERSAMPLE / 2);

  logic [CNT_WIDTH-1:0]  active_div;
  logic [FRAC_WIDTH-1:0] active_frac;
  logic [CNT_WIDTH-1:0]  shadow_div;
  logic [FRAC_WIDTH-1:0] shadow_frac;
  logic                  pend;
  logic [CNT_WIDTH-1:0]  cnt;
  logic [FRAC_WIDTH-1:0] acc;
  logic [IDX_WIDTH-1:0]  os_idx;

  logic [CNT_WIDTH-1:0]  div_clamp;
  logic [CNT_WIDTH-1:0]  bnd_div;
  logic [FRAC_WIDTH-1:0] bnd_frac;
  logic [FRAC_WIDTH-1:0] acc_next;
  logic                  carry;
  logic [CNT_WIDTH-1:0]  reload;
  logic [IDX_WIDTH-1:0]  idx_next;

  // Boundary arithmetic: clamp the incoming divisor, pick shadow values when a
  // load is pending, then form the next accumulator and counter reload value.
  always_comb begin
    div_clamp = (bus.div_in < CNT_TWO) ? CNT_TWO : bus.div_in;
    bnd_div   = pend ? shadow_div  : active_div;
    bnd_frac  = pend ? shadow_frac : active_frac;
    {carry, acc_next} = {1'b0, acc} + {1'b0, bnd_frac};
    // bnd_div >= 2, so the decrement cannot wrap and +carry cannot overflow.
    reload    = bnd_div - CNT_ONE + {{(CNT_WIDTH-1){1'b0}}, carry};
    idx_next  = (os_idx == IDX_LAST) ? '0 : os_idx + 1'b1;
  end

  // Divisor staging, period counter, fractional accumulator and tick outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_div   <= DIV_RST;
      active_frac  <= '0;
      shadow_div   <= DIV_RST;
      shadow_frac  <= '0;
      pend         <= 1'b0;
      cnt          <= DIV_RST - CNT_ONE;
      acc          <= '0;
      os_idx       <= '0;
      bus.os_tick  <= 1'b0;
      bus.mid_tick <= 1'b0;
      bus.bit_tick <= 1'b0;
    end else begin
      bus.os_tick  <= 1'b0;
      bus.mid_tick <= 1'b0;
      bus.bit_tick <= 1'b0;
      if (bus.resync) begin
        // Phase restart wins over counting; a simultaneous load takes effect
        // immediately rather than waiting for a boundary.
        acc    <= '0;
        os_idx <= '0;
        if (bus.load) begin
          active_div  <= div_clamp;
          active_frac <= bus.frac_in;
          shadow_div  <= div_clamp;
          shadow_frac <= bus.frac_in;
          pend        <= 1'b0;
          cnt         <= div_clamp - CNT_ONE;
        end else begin
          cnt <= active_div - CNT_ONE;
        end
      end else begin
        if (bus.load) begin
          shadow_div  <= div_clamp;
          shadow_frac <= bus.frac_in;
          pend        <= 1'b1;
        end
        if (!bus.en) begin
          // Idle: no period is in flight to protect, so apply staged values now.
          if (pend) begin
            active_div  <= shadow_div;
            active_frac <= shadow_frac;
            if (!bus.load) pend <= 1'b0;
          end
        end else if (cnt != '0) begin
          cnt <= cnt - CNT_ONE;
        end else begin
          bus.os_tick  <= 1'b1;
          bus.bit_tick <= (idx_next == '0);
          bus.mid_tick <= (idx_next == IDX_MID);
          cnt          <= reload;
          acc          <= acc_next;
          os_idx       <= idx_next;
          // A load landing on this same edge uses the older shadow values and
          // stays pending for the next boundary.
          if (pend) begin
            active_div  <= shadow_div;
            active_frac <= shadow_frac;
            if (!bus.load) pend <= 1'b0;
          end
        end
      end
    end
  end

endmodule
